debug_tx_scheduler: RTL and testbench
=====================================

// Module: debug_tx_scheduler
// PURPOSE
//  Debug-unit sequencer that streams one MIPS state dump over the UART transmitter.
//  On request it sends, as bytes: header, PC, the register file, the data-memory window, trailer.
//  Owns the register-file and data-memory debug read ports.
//  Sits between the datapath debug taps and the UART TX, and is the sole driver of tx_start.
// PARAMETERS
//  NB_DATA      32     width of PC / register / memory words (multiple of 8)
//  NB_REG_ADDR  5      register-file debug address width
//  N_REGS       32     registers dumped, addresses 0..N_REGS-1 (0 = section skipped)
//  NB_MEM_ADDR  5      data-memory debug address width
//  N_MEM_WORDS  32     memory words dumped, addresses 0..N_MEM_WORDS-1 (0 = skipped)
//  HDR_BYTE     8'hA5  frame header byte
//  TRL_BYTE     8'h5A  frame trailer byte
// PORTS
//  clk            in   1            single clock; all state on rising edge
//  reset_n        in   1            reset; asynchronous, active-low
//  i_dump_req     in   1            start-dump pulse
//  i_pc           in   NB_DATA      current PC, captured on the accepted request
//  o_reg_addr     out  NB_REG_ADDR  register-file debug read address
//  i_reg_data     in   NB_DATA      register data, valid 1 cycle after o_reg_addr
//  o_mem_addr     out  NB_MEM_ADDR  data-memory debug read address
//  i_mem_data     in   NB_DATA      memory data, valid 1 cycle after o_mem_addr
//  o_tx_start     out  1            1-cycle pulse: UART TX loads o_tx_data
//  o_tx_data      out  8            byte to transmit; held stable until i_tx_done_tick
//  i_tx_done_tick in   1            UART TX finished the current byte
//  o_busy         out  1            high from accepted request until o_done
//  o_done         out  1            1-cycle pulse after the trailer completes
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; counters and word register cleared.
//  - Reset asserted mid-frame aborts immediately.
//  - No resume after an abort; the next request starts a fresh frame.
//  - FSM states: IDLE, HDR, PC, REG_RD, REG_TX, MEM_RD, MEM_TX, TRL, FIN.
//  - IDLE: i_dump_req=1 latches i_pc into the word register, sets o_busy, and moves to HDR.
//  - Requests while o_busy=1 are ignored, not queued.
//  - Byte send, in every TX state: cycle 1 drives o_tx_data and pulses o_tx_start.
//    The FSM then waits for i_tx_done_tick.
//    Only one byte is in flight at a time.
//    i_tx_done_tick outside the wait phase is ignored.
//  - Word send: 4 bytes, MSB first ([31:24] first).
//    A 2-bit byte index selects the byte; the word is done after index 3's tick.
//  - HDR -> PC (4 bytes) -> REG_RD.
//  - REG_RD: drive o_reg_addr=k; the next cycle, latch i_reg_data; go to REG_TX.
//  - REG_TX: send the word. If k==N_REGS-1, go to MEM_RD with k cleared; else k+1 -> REG_RD.
//  - MEM_RD / MEM_TX: same pattern on the memory port with N_MEM_WORDS.
//  - Then TRL (1 byte) -> FIN.
//  - FIN: pulse o_done for one cycle, drop o_busy in the same cycle, return to IDLE.
//  - N_REGS=0 or N_MEM_WORDS=0 skips that section entirely; no read is issued.
//  - Counters are sized $clog2(N+1) and never wrap mid-section.
//  - Unused high address bits are driven 0.
//  - Latency: request at cycle t gives o_tx_start (HDR) at t+1.
//    Trailer's done tick at t gives o_done at t+1.
//  - Frame length = 2 + 4*(1+N_REGS+N_MEM_WORDS) bytes (262 at defaults).
//  - A done tick in the same cycle as a new request: the request is ignored (still busy).
//  - o_reg_addr / o_mem_addr hold their last value between reads; no combinational loops.
// STRUCTURE
//  - Package debug_pkg: FSM state localparams, HDR/TRL defaults, byte-index width.
//    The package is shared with the future RX command decoder.
//  - Sub-module word_byte_sender:
//    - Inputs: word, go. Outputs: tx_start, tx_data, word_done.
//    - Handles the 4-byte MSB-first sequence and the done-tick wait.
//    - The top FSM only sequences sections and addresses.
// TESTING
//  T1 Basic frame: N_REGS=2, N_MEM_WORDS=1, pc=32'h0000_0040, reg0=32'h1122_3344, reg1=0,
//     mem0=32'hDEAD_BEEF, UART model ticks 10 cycles after each start.
//     -> byte stream A5 00 00 00 40 11 22 33 44 00 00 00 00 DE AD BE EF 5A.
//     -> o_done pulse after the 18th tick.
//  T2 Handshake: hold i_tx_done_tick low for 500 cycles.
//     -> exactly one o_tx_start; o_tx_data stable; no further progress.
//  T3 Busy request: pulse i_dump_req mid-frame.
//     -> frame unchanged; exactly one o_done; no second frame.
//  T4 Reset abort: assert reset_n=0 during REG_TX byte 2.
//     -> all outputs 0 asynchronously.
//     -> a new request produces a full fresh frame starting with A5.
//  T5 Empty sections: N_REGS=0, N_MEM_WORDS=0 -> frame A5 + 4 PC bytes + 5A (6 bytes).
//     -> no change on o_reg_addr / o_mem_addr.
//  T6 Spurious ticks: i_tx_done_tick pulses while in IDLE and in RD states.
//     -> ignored; stream and byte count match T1.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: shared debug-unit types and constants (scheduler and future RX command decoder).
package debug_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_PC, ST_REG_RD, ST_REG_TX, ST_MEM_RD, ST_MEM_TX, ST_TRL, ST_FIN
    } dbg_state_e;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] TRL_BYTE_DEF = 8'h5A;
    localparam int BIDX_W = 2;
    // Counter width for 0..n, never narrower than one bit so empty sections still elaborate.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/debug_tx_scheduler_word_byte_sender.sv
// word_byte_sender: sends a word MSB-first one byte at a time, waiting for each UART done tick.
module word_byte_sender
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NB_DATA-1:0] word_i,
    input  logic               single_i,
    input  logic               go_i,
    input  logic               tx_done_tick_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    output logic               word_done_o
);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NB_DATA / 8 - 1);
    logic [BIDX_W-1:0] idx_q;
    logic              wait_q;
    logic              last;
    logic              tick;
    // Single-byte sends (header/trailer) put the byte in the top lane and stop after index 0.
    always_comb begin
        last        = single_i || idx_q == LAST_IDX;
        tick        = go_i && wait_q && tx_done_tick_i;
        tx_start_o  = go_i && !wait_q;
        word_done_o = tick && last;
        tx_data_o   = 8'h00;
        for (int b = 0; b < NB_DATA / 8; b++)
            if (go_i && idx_q == BIDX_W'(b)) tx_data_o = word_i[NB_DATA-1-8*b -: 8];
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            idx_q  <= '0;
            wait_q <= 1'b0;
        end else if (tx_start_o) begin
            wait_q <= 1'b1;
        end else if (tick) begin
            wait_q <= 1'b0;
            idx_q  <= last ? '0 : idx_q + 1'b1;
        end
endmodule

// File: rtl/debug_tx_scheduler.sv
// debug_tx_scheduler: streams header, PC, register file, memory window and trailer over UART TX.
module debug_tx_scheduler
    import debug_pkg::*;
#(
    parameter int         NB_DATA     = 32,
    parameter int         NB_REG_ADDR = 5,
    parameter int         N_REGS      = 32,
    parameter int         NB_MEM_ADDR = 5,
    parameter int         N_MEM_WORDS = 32,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter logic [7:0] TRL_BYTE    = TRL_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_dump_req,
    input  logic [NB_DATA-1:0]     i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done_tick,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int            KW       = cnt_w(N_REGS > N_MEM_WORDS ? N_REGS : N_MEM_WORDS);
    localparam logic [KW-1:0] LAST_REG = KW'(N_REGS - 1);
    localparam logic [KW-1:0] LAST_MEM = KW'(N_MEM_WORDS - 1);
    localparam bit            HAS_REGS = N_REGS > 0;
    localparam bit            HAS_MEM  = N_MEM_WORDS > 0;

    dbg_state_e             state_q;
    logic [NB_DATA-1:0]     word_q;
    logic [KW-1:0]          k_q;
    logic [KW-1:0]          k_nx;
    logic                   rd_q;
    logic [NB_REG_ADDR-1:0] reg_addr_q;
    logic [NB_MEM_ADDR-1:0] mem_addr_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   go;
    logic                   single;
    logic                   word_done;
    logic [NB_DATA-1:0]     word_in;

    always_comb begin
        k_nx    = k_q + 1'b1;
        go      = state_q inside {ST_HDR, ST_PC, ST_REG_TX, ST_MEM_TX, ST_TRL};
        single  = state_q == ST_HDR || state_q == ST_TRL;
        word_in = state_q == ST_HDR ? {HDR_BYTE, {(NB_DATA-8){1'b0}}} :
                  state_q == ST_TRL ? {TRL_BYTE, {(NB_DATA-8){1'b0}}} : word_q;
    end

    word_byte_sender #(.NB_DATA(NB_DATA)) u_sender (
        .clk           (clk),
        .reset_n       (reset_n),
        .word_i        (word_in),
        .single_i      (single),
        .go_i          (go),
        .tx_done_tick_i(i_tx_done_tick),
        .tx_start_o    (o_tx_start),
        .tx_data_o     (o_tx_data),
        .word_done_o   (word_done)
    );

    // Read addresses are loaded on entry to a RD state; data is latched on its second cycle.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            k_q        <= '0;
            rd_q       <= 1'b0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (i_dump_req) begin
                    word_q  <= i_pc;
                    busy_q  <= 1'b1;
                    state_q <= ST_HDR;
                end
                ST_HDR: if (word_done) state_q <= ST_PC;
                ST_PC: if (word_done) begin
                    k_q <= '0;
                    if (HAS_REGS) begin
                        reg_addr_q <= '0;
                        state_q    <= ST_REG_RD;
                    end else if (HAS_MEM) begin
                        mem_addr_q <= '0;
                        state_q    <= ST_MEM_RD;
                    end else begin
                        state_q <= ST_TRL;
                    end
                end
                ST_REG_RD: begin
                    rd_q <= !rd_q;
                    if (rd_q) begin
                        word_q  <= i_reg_data;
                        state_q <= ST_REG_TX;
                    end
                end
                ST_REG_TX: if (word_done) begin
                    if (k_q == LAST_REG) begin
                        k_q <= '0;
                        if (HAS_MEM) begin
                            mem_addr_q <= '0;
                            state_q    <= ST_MEM_RD;
                        end else begin
                            state_q <= ST_TRL;
                        end
                    end else begin
                        k_q        <= k_nx;
                        reg_addr_q <= NB_REG_ADDR'(k_nx);
                        state_q    <= ST_REG_RD;
                    end
                end
                ST_MEM_RD: begin
                    rd_q <= !rd_q;
                    if (rd_q) begin
                        word_q  <= i_mem_data;
                        state_q <= ST_MEM_TX;
                    end
                end
                ST_MEM_TX: if (word_done) begin
                    if (k_q == LAST_MEM) begin
                        k_q     <= '0;
                        state_q <= ST_TRL;
                    end else begin
                        k_q        <= k_nx;
                        mem_addr_q <= NB_MEM_ADDR'(k_nx);
                        state_q    <= ST_MEM_RD;
                    end
                end
                ST_TRL: if (word_done) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_FIN;
                end
                ST_FIN: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end

    assign o_reg_addr = reg_addr_q;
    assign o_mem_addr = mem_addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
endmodule

// File: tb/tb_debug_tx_scheduler.sv
// tb_debug_tx_scheduler: UART/memory models around two scheduler instances (2/1 words and empty sections).
module tb_debug_tx_scheduler;
    localparam int NR [2] = '{2, 0};
    localparam int NM [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req [2];
    logic        start [2];
    logic        tick [2];
    logic        busy [2];
    logic        done [2];
    logic [31:0] pc [2];
    logic [31:0] rdata [2];
    logic [31:0] mdata [2];
    logic [4:0]  raddr [2];
    logic [4:0]  maddr [2];
    logic [7:0]  data [2];
    logic [31:0] rf [2][32];
    logic [31:0] mm [2][32];

    logic [7:0]  got [2][4096];
    logic [7:0]  cur [2];
    int          ng [2], ndone [2], done_at [2], viol [2], dly [2], cnt [2];
    int          tick_cyc [2], done_cyc [2];
    int          cyc, addr_chg;
    bit          pend [2], hold [2], spur [2];
    int          n_chk, n_pass;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    debug_tx_scheduler #(.N_REGS(2), .N_MEM_WORDS(1)) dut (
        .clk(clk), .reset_n(reset_n), .i_dump_req(req[0]), .i_pc(pc[0]),
        .o_reg_addr(raddr[0]), .i_reg_data(rdata[0]), .o_mem_addr(maddr[0]), .i_mem_data(mdata[0]),
        .o_tx_start(start[0]), .o_tx_data(data[0]), .i_tx_done_tick(tick[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    debug_tx_scheduler #(.N_REGS(0), .N_MEM_WORDS(0)) dut_empty (
        .clk(clk), .reset_n(reset_n), .i_dump_req(req[1]), .i_pc(pc[1]),
        .o_reg_addr(raddr[1]), .i_reg_data(rdata[1]), .o_mem_addr(maddr[1]), .i_mem_data(mdata[1]),
        .o_tx_start(start[1]), .o_tx_data(data[1]), .i_tx_done_tick(tick[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    // Synchronous-read register file and data memory.
    always @(posedge clk)
        for (int g = 0; g < 2; g++) begin
            rdata[g] <= rf[g][raddr[g]];
            mdata[g] <= mm[g][maddr[g]];
        end

    // UART model: records each started byte, ticks dly cycles later, flags protocol breaches.
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            tick[g] = 1'b0;
            if (!reset_n) begin
                pend[g] = 1'b0;
            end else begin
                if (done[g]) begin
                    ndone[g]++;
                    done_at[g]  = ng[g];
                    done_cyc[g] = cyc;
                    if (busy[g]) viol[g]++;
                end
                if (pend[g]) begin
                    if (start[g] || data[g] != cur[g]) viol[g]++;
                    if (!hold[g]) begin
                        cnt[g]--;
                        if (cnt[g] <= 0) begin
                            tick[g]     = 1'b1;
                            pend[g]     = 1'b0;
                            tick_cyc[g] = cyc;
                        end
                    end
                end else if (start[g]) begin
                    got[g][ng[g] % 4096] = data[g];
                    ng[g]++;
                    cur[g]  = data[g];
                    pend[g] = 1'b1;
                    cnt[g]  = dly[g];
                end else if (spur[g] && $urandom_range(0, 2) == 0) begin
                    tick[g] = 1'b1;
                end
            end
        end
        if (raddr[1] != 0 || maddr[1] != 0) addr_chg++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic build(input int g, input logic [31:0] pcv);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        push_word(pcv);
        for (int r = 0; r < NR[g]; r++) push_word(rf[g][r]);
        for (int m = 0; m < NM[g]; m++) push_word(mm[g][m]);
        exp_q.push_back(8'h5A);
    endtask

    task automatic launch(input int g, input logic [31:0] pcv, output int base, output int nd);
        @(negedge clk);
        build(g, pcv);
        base   = ng[g];
        nd     = ndone[g];
        pc[g]  = pcv;
        req[g] = 1'b1;
        @(negedge clk);
        req[g] = 1'b0;
        check("start_latency", {31'b0, start[g]}, 1);
        check("busy_set", {31'b0, busy[g]}, 1);
    endtask

    task automatic finish(input int g, input int base, input int nd, input int midreq);
        int  t = 0;
        bit  sent = 0;
        while (ndone[g] == nd && t < 20000) begin
            @(negedge clk);
            t++;
            req[g] = 1'b0;
            if (midreq >= 0 && !sent && ng[g] - base >= midreq) begin
                req[g] = 1'b1;
                sent   = 1'b1;
            end
        end
        req[g] = 1'b0;
        check("frame_timeout", {31'b0, t < 20000}, 1);
        check("frame_len", ng[g] - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), {24'b0, got[g][(base + i) % 4096]}, {24'b0, exp_q[i]});
        check("done_after_bytes", done_at[g] - base, exp_q.size());
        check("done_latency", done_cyc[g] - tick_cyc[g], 1);
        check("protocol", viol[g], 0);
    endtask

    initial begin
        int base, nd;
        req  = '{1'b0, 1'b0};
        pc   = '{32'h0, 32'h0};
        hold = '{1'b0, 1'b0};
        spur = '{1'b0, 1'b0};
        dly  = '{10, 10};
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 32; i++) begin
                rf[g][i] = $urandom;
                mm[g][i] = $urandom;
            end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            check("reset_outputs", {11'b0, start[g], data[g], busy[g], done[g], raddr[g], maddr[g]}, 0);
        reset_n = 1'b1;

        // Basic frame with fixed contents.
        rf[0][0] = 32'h1122_3344;
        rf[0][1] = 32'h0;
        mm[0][0] = 32'hDEAD_BEEF;
        launch(0, 32'h0000_0040, base, nd);
        finish(0, base, nd, -1);

        // Spurious ticks in IDLE and read states must not disturb the same frame.
        spur[0] = 1'b1;
        repeat (20) @(negedge clk);
        launch(0, 32'h0000_0040, base, nd);
        finish(0, base, nd, -1);
        repeat (20) @(negedge clk);
        check("spur_idle_no_start", ng[0] - base, 18);
        spur[0] = 1'b0;

        // Stalled UART: one byte in flight, held stable, no progress.
        hold[0] = 1'b1;
        launch(0, $urandom, base, nd);
        repeat (500) @(negedge clk);
        check("stall_one_start", ng[0] - base, 1);
        check("stall_data", {24'b0, data[0]}, 32'hA5);
        check("stall_no_done", ndone[0] - nd, 0);
        check("stall_busy", {31'b0, busy[0]}, 1);
        check("stall_stable", viol[0], 0);
        hold[0] = 1'b0;
        finish(0, base, nd, -1);

        // Request while busy is dropped.
        launch(0, $urandom, base, nd);
        finish(0, base, nd, 8);
        repeat (300) @(negedge clk);
        check("busy_req_one_done", ndone[0] - nd, 1);
        check("busy_req_no_frame", ng[0] - base, exp_q.size());
        check("busy_req_idle", {31'b0, busy[0]}, 0);

        // Asynchronous abort during the third byte of register 0, then a fresh frame.
        launch(0, $urandom, base, nd);
        for (int t = 0; t < 5000 && ng[0] - base < 8; t++) @(negedge clk);
        check("abort_reached", ng[0] - base, 8);
        #2 reset_n = 1'b0;
        #1 check("abort_outputs", {11'b0, start[0], data[0], busy[0], done[0], raddr[0], maddr[0]}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_resume", {31'b0, busy[0]}, 0);
        launch(0, $urandom, base, nd);
        finish(0, base, nd, -1);

        // Empty sections: header, PC, trailer only; read ports untouched.
        for (int k = 0; k < 2; k++) begin
            dly[1] = $urandom_range(1, 12);
            launch(1, $urandom, base, nd);
            finish(1, base, nd, -1);
        end
        check("empty_addr_idle", addr_chg, 0);

        // Randomized frames.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) begin
                rf[0][i] = $urandom;
                mm[0][i] = $urandom;
            end
            dly[0]  = $urandom_range(1, 12);
            spur[0] = 1'($urandom_range(0, 1));
            launch(0, $urandom, base, nd);
            finish(0, base, nd, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
